// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall request.
// Optional build macro ID_EX_PERF_CNT_EN adds saturating stall/flush performance counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_wr,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_wr,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [XLEN-1:0]   ex_alu_a,
  output logic [XLEN-1:0]   ex_alu_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              stall_id_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  // Valid semantics: ex_valid=1 marks a real instruction in EX; there is no ready.
  // The pipe advances every cycle unless stall_i holds it, and a bubble has valid=0.
  logic              valid_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic              use_imm_q;
  logic              reg_write_q;
  logic              is_load_q;

  logic              load_use;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  always_comb begin
    load_use = valid_q && is_load_q && (rd_q != '0) && id_valid &&
               ((rd_q == id_rs1_addr) || (!id_use_imm && (rd_q == id_rs2_addr)));
  end

  // A flush also kills ID upstream, so stalling it would be pointless.
  assign stall_id_o = load_use && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i || (!stall_i && load_use)) begin
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= id_valid;
      alu_op_q    <= id_alu_op;
      rs1_q       <= id_rs1_addr;
      rs2_q       <= id_rs2_addr;
      rd_q        <= id_rd_addr;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      reg_write_q <= id_reg_write;
      is_load_q   <= id_is_load;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_wr && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
      fwd_rs1 = memwb_result;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_wr && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
      fwd_rs2 = memwb_result;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_alu_a      = fwd_rs1;
  assign ex_alu_b      = use_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = reg_write_q && valid_q;
  assign ex_is_load    = is_load_q && valid_q;

`ifdef ID_EX_PERF_CNT_EN
  // Counters freeze with the rest of the pipe while stall_i holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (!stall_i) begin
      if (stall_id_o && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_i && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// checked by a scoreboard against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int OW    = 4;
  localparam int OUT_W = 1 + OW + 3 * XLEN + AW + 3;

  typedef struct {
    logic            rst_n;
    logic            id_valid;
    logic [OW-1:0]   op;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            rw;
    logic            ld;
    logic            flush;
    logic            stall;
    logic [AW-1:0]   exmem_rd;
    logic            exmem_wr;
    logic [XLEN-1:0] exmem_res;
    logic [AW-1:0]   memwb_rd;
    logic            memwb_wr;
    logic [XLEN-1:0] memwb_res;
  } stim_t;

  // The instruction the model believes is sitting in EX.
  typedef struct {
    logic            valid;
    logic [OW-1:0]   op;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            rw;
    logic            ld;
  } ex_t;

  // clock/reset and DUT signals
  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [OW-1:0]   id_alu_op;
  logic [AW-1:0]   id_rs1_addr;
  logic [AW-1:0]   id_rs2_addr;
  logic [AW-1:0]   id_rd_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic            id_reg_write;
  logic            id_is_load;
  logic            flush_i;
  logic            stall_i;
  logic [AW-1:0]   exmem_rd;
  logic            exmem_wr;
  logic [XLEN-1:0] exmem_result;
  logic [AW-1:0]   memwb_rd;
  logic            memwb_wr;
  logic [XLEN-1:0] memwb_result;
  logic            ex_valid;
  logic [OW-1:0]   ex_alu_op;
  logic [XLEN-1:0] ex_alu_a;
  logic [XLEN-1:0] ex_alu_b;
  logic [XLEN-1:0] ex_store_data;
  logic [AW-1:0]   ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_is_load;
  logic            stall_id_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_flush_cnt;
`endif

  logic [OUT_W-1:0] exp_q[$];
  int               checks;
  int               errors;
  ex_t              m;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(AW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush_i(flush_i), .stall_i(stall_i),
    .exmem_rd(exmem_rd), .exmem_wr(exmem_wr), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_wr(memwb_wr), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .stall_id_o(stall_id_o)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic ex_t bubble();
    ex_t e;
    e.valid = 1'b0; e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.d1 = '0; e.d2 = '0; e.imm = '0; e.use_imm = 1'b0; e.rw = 1'b0; e.ld = 1'b0;
    return e;
  endfunction

  function automatic logic [XLEN-1:0] operand(logic [AW-1:0] rs, logic [XLEN-1:0] rf, stim_t s);
    if (rs == 0) return rf;
    if (s.exmem_wr && s.exmem_rd == rs) return s.exmem_res;
    if (s.memwb_wr && s.memwb_rd == rs) return s.memwb_res;
    return rf;
  endfunction

  function automatic logic hazard(ex_t e, stim_t s);
    bit reads_rd;
    reads_rd = (s.rs1 == e.rd) || (!s.use_imm && s.rs2 == e.rd);
    return e.valid && e.ld && e.rd != 0 && s.id_valid && reads_rd;
  endfunction

  function automatic logic [OUT_W-1:0] expect_out(ex_t e, stim_t s);
    logic [XLEN-1:0] a, st, b;
    logic            stall;
    a     = operand(e.rs1, e.d1, s);
    st    = operand(e.rs2, e.d2, s);
    b     = e.use_imm ? e.imm : st;
    stall = hazard(e, s) && !s.flush;
    return {e.valid, e.op, a, b, st, e.rd, e.valid & e.rw, e.valid & e.ld, stall};
  endfunction

  function automatic ex_t advance(ex_t e, stim_t s);
    ex_t n;
    if (!s.rst_n || s.flush) return bubble();
    if (s.stall) return e;
    if (hazard(e, s)) return bubble();
    n.valid = s.id_valid; n.op = s.op; n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
    n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm; n.use_imm = s.use_imm; n.rw = s.rw; n.ld = s.ld;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic stim_t nop();
    stim_t s;
    s.rst_n = 1'b1; s.id_valid = 1'b0; s.op = '0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
    s.d1 = '0; s.d2 = '0; s.imm = '0; s.use_imm = 1'b0; s.rw = 1'b0; s.ld = 1'b0;
    s.flush = 1'b0; s.stall = 1'b0;
    s.exmem_rd = '0; s.exmem_wr = 1'b0; s.exmem_res = '0;
    s.memwb_rd = '0; s.memwb_wr = 1'b0; s.memwb_res = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n     = ($urandom_range(0, 63) != 0);
    s.id_valid  = ($urandom_range(0, 7) != 0);
    s.op        = OW'($urandom_range(0, 15));
    s.rs1       = AW'($urandom_range(0, 7));
    s.rs2       = AW'($urandom_range(0, 7));
    s.rd        = AW'($urandom_range(0, 7));
    s.d1        = $urandom;
    s.d2        = $urandom;
    s.imm       = $urandom;
    s.use_imm   = 1'($urandom_range(0, 1));
    s.rw        = 1'($urandom_range(0, 1));
    s.ld        = ($urandom_range(0, 2) == 0);
    s.flush     = ($urandom_range(0, 9) == 0);
    s.stall     = ($urandom_range(0, 7) == 0);
    s.exmem_rd  = AW'($urandom_range(0, 7));
    s.exmem_wr  = 1'($urandom_range(0, 1));
    s.exmem_res = $urandom;
    s.memwb_rd  = AW'($urandom_range(0, 7));
    s.memwb_wr  = 1'($urandom_range(0, 1));
    s.memwb_res = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; id_valid = s.id_valid; id_alu_op = s.op;
    id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; id_rd_addr = s.rd;
    id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm; id_use_imm = s.use_imm;
    id_reg_write = s.rw; id_is_load = s.ld; flush_i = s.flush; stall_i = s.stall;
    exmem_rd = s.exmem_rd; exmem_wr = s.exmem_wr; exmem_result = s.exmem_res;
    memwb_rd = s.memwb_rd; memwb_wr = s.memwb_wr; memwb_result = s.memwb_res;
  endtask

  // One cycle: drive at negedge, predict outputs for this cycle, then retire the edge in the model.
  task automatic step(input stim_t s);
    @(negedge clk);
    apply(s);
    #1;
    exp_q.push_back(expect_out(m, s));
    @(posedge clk);
    m = advance(m, s);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OUT_W-1:0] act;
    logic [OUT_W-1:0] exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data, ex_rd_addr,
               ex_reg_write, ex_is_load, stall_id_o};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL ex_outputs t=%0t got=%h expected=%h (valid,op,a,b,store,rd,rw,ld,stall)",
                   $time, act, exp_v);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    stim_t t;
    stim_t u;
    checks = 0;
    errors = 0;

    // Two reset cycles with a live instruction presented in ID.
    t = nop();
    t.rst_n = 1'b0; t.id_valid = 1'b1; t.rs1 = 5'd1; t.rd = 5'd2; t.rw = 1'b1; t.d1 = 32'h55;
    apply(t);
    @(posedge clk);
    m = bubble();
    step(t);

    // add x3,x1,x2 then add x4,x3,x3 with x3 forwarded from EX/MEM.
    t = nop();
    t.id_valid = 1'b1; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd = 5'd3; t.d1 = 32'd5; t.d2 = 32'd7; t.rw = 1'b1;
    step(t);
    t = nop();
    t.id_valid = 1'b1; t.rs1 = 5'd3; t.rs2 = 5'd3; t.rd = 5'd4; t.rw = 1'b1;
    step(t);
    t = nop();
    t.exmem_rd = 5'd3; t.exmem_wr = 1'b1; t.exmem_res = 32'd12;
    step(t);

    // EX/MEM vs MEM/WB priority on the same destination, with EX held by stall_i.
    t = nop();
    t.id_valid = 1'b1; t.rs1 = 5'd6; t.rs2 = 5'd1; t.rd = 5'd8; t.d1 = 32'h66; t.d2 = 32'h11; t.rw = 1'b1;
    step(t);
    t = nop();
    t.stall = 1'b1;
    t.exmem_rd = 5'd6; t.exmem_wr = 1'b1; t.exmem_res = 32'hA;
    t.memwb_rd = 5'd6; t.memwb_wr = 1'b1; t.memwb_res = 32'hB;
    step(t);
    t.exmem_wr = 1'b0;
    step(t);

    // Load-use on x5: one stall cycle, bubble, then issue and take the MEM/WB forward.
    t = nop();
    t.id_valid = 1'b1; t.rs1 = 5'd2; t.rd = 5'd5; t.imm = 32'd4; t.use_imm = 1'b1; t.ld = 1'b1; t.rw = 1'b1;
    step(t);
    u = nop();
    u.id_valid = 1'b1; u.rs1 = 5'd5; u.rs2 = 5'd1; u.rd = 5'd9; u.d2 = 32'd3; u.rw = 1'b1;
    step(u);
    u.exmem_rd = 5'd5; u.exmem_wr = 1'b1; u.exmem_res = 32'hDEAD;
    step(u);
    t = nop();
    t.memwb_rd = 5'd5; t.memwb_wr = 1'b1; t.memwb_res = 32'h1234;
    step(t);

    // Load-use coinciding with flush, then a 3-cycle downstream hold.
    t = nop();
    t.id_valid = 1'b1; t.rs1 = 5'd1; t.rd = 5'd7; t.ld = 1'b1; t.rw = 1'b1;
    step(t);
    u = nop();
    u.id_valid = 1'b1; u.rs1 = 5'd7; u.rd = 5'd10; u.d1 = 32'h77; u.rw = 1'b1; u.flush = 1'b1;
    step(u);
    u.flush = 1'b0;
    step(u);
    for (int i = 0; i < 3; i++) begin
      t = rand_stim();
      t.rst_n = 1'b1; t.flush = 1'b0; t.stall = 1'b1; t.exmem_wr = 1'b0; t.memwb_wr = 1'b0;
      step(t);
    end

    // x0 is never forwarded.
    t = nop();
    t.id_valid = 1'b1; t.rd = 5'd0; t.rw = 1'b1;
    step(t);
    t = nop();
    t.exmem_rd = 5'd0; t.exmem_wr = 1'b1; t.exmem_res = 32'hFFFF_FFFF;
    t.memwb_rd = 5'd0; t.memwb_wr = 1'b1; t.memwb_res = 32'hFFFF_FFFF;
    step(t);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(rand_stim());
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #3;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
